l2_prefetch_fill_ctrl: RTL

Sequencer that owns the write port of the L2 prefetch buffer and keeps it consistent. It performs the power-on and flush invalidate sweep, turns CPU read misses into wrapping line-fill bursts from main memory, and merges CPU write snoops into the same port with priority over fill data. It sits between the CPU bus interface, the memory controller and the prefetch tag/data RAMs.

---
 rtl/prefetch_pkg.sv | 58 +++++
 rtl/prefetch_wr_mux.sv | 57 +++++
 rtl/l2_prefetch_fill_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/prefetch_pkg.sv
// Shared types, geometry and address helpers for the L2 prefetch buffer.
package prefetch_pkg;

  localparam int LINE_WORDS = 8;                   // words per fill burst
  localparam int IDX_W      = 7;                   // buffer index width (word granular)
  localparam int ADDR_W     = 26;                  // word address [27:2]
  localparam int DATA_W     = 32;
  localparam int OFF_W      = $clog2(LINE_WORDS);  // word-in-line offset
  localparam int SET_W      = IDX_W - OFF_W;       // line index inside the buffer
  localparam int TAG_W      = ADDR_W - IDX_W;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DRAIN
  } state_t;

  // Word address split as seen by the buffer: {tag, line index, word offset}.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SET_W-1:0] set;
    logic [OFF_W-1:0] off;
  } addr_split_t;

  // One write-port request; last marks the final word of a fill.
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [3:0]        m;
    logic              clr;
    logic              last;
  } wr_req_t;

  function automatic addr_split_t addr_split(input logic [ADDR_W-1:0] a);
    return addr_split_t'(a);
  endfunction

  // True when both word addresses fall in the same aligned line.
  function automatic logic same_line(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
    logic [ADDR_W-1:0] x;
    x = a ^ b;
    return (x >> OFF_W) == '0;
  endfunction

  // Critical-word-first address: offset wraps inside the aligned line.
  function automatic logic [ADDR_W-1:0] fill_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [OFF_W-1:0]  cnt);
    addr_split_t s;
    s     = addr_split(base);
    s.off = s.off + cnt;
    return s;
  endfunction

endpackage

// File: rtl/prefetch_wr_mux.sv
// Write-port arbiter: sweep > snoop > fill, with a one-entry skid for fill
// words displaced by a snoop. All port outputs come straight from flops.
module prefetch_wr_mux
  import prefetch_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  wr_req_t i_sweep,
  input  wr_req_t i_snoop,
  input  wr_req_t i_fill,
  input  logic    i_kill,   // snoop hit the line being filled: drop queued fill data
  output wr_req_t o_wr
);

  wr_req_t r_out, r_skid;
  wr_req_t w_out, w_skid;

  // Select the next port write and the next skid content.
  always_comb begin
    w_out  = '0;
    w_skid = r_skid;
    if (i_sweep.vld) begin
      // the sweep invalidates everything, so a parked fill word is moot
      w_out  = i_sweep;
      w_skid = '0;
    end else if (i_snoop.vld) begin
      w_out = i_snoop;
      if (i_kill)
        w_skid = '0;
      else if (!r_skid.vld)
        w_skid = i_fill;
      // relies on snoop spacing: skid is drained before the next snoop lands
    end else if (r_skid.vld) begin
      // keep fill order: oldest word first, newcomer takes the skid slot
      w_out  = r_skid;
      w_skid = i_fill;
    end else begin
      w_out = i_fill;
    end
    if (!w_out.vld)
      w_out = '0;
  end

  // Output and skid registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      r_out  <= w_out;
      r_skid <= w_skid;
    end
  end

  assign o_wr = r_out;

endmodule

// File: rtl/l2_prefetch_fill_ctrl.sv
// L2 prefetch buffer write-port sequencer: invalidate sweep, wrapping line
// fills from memory, and snoop write merging.
module l2_prefetch_fill_ctrl
  import prefetch_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              MissReq,
  input  logic [ADDR_W-1:0] MissA,
  input  logic              Flush,
  input  logic              SnWR,
  input  logic [ADDR_W-1:0] SnA,
  input  logic [DATA_W-1:0] SnD,
  input  logic [3:0]        SnM,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemA,
  input  logic              MemAck,
  input  logic              MemRDV,
  input  logic [DATA_W-1:0] MemRD,
  output logic [ADDR_W-1:0] WRA,
  output logic [DATA_W-1:0] WRD,
  output logic              WR,
  output logic [3:0]        WRM,
  output logic              CLR,
  output logic              Busy,
  output logic              FillDone
);

  state_t            r_state, w_nxt;
  logic [IDX_W:0]    r_cnt;         // sweep index; MSB set = sweep complete
  logic [OFF_W-1:0]  r_wcnt;        // burst word counter
  logic [ADDR_W-1:0] r_base;        // miss address, also drives MemA
  logic              r_flush_pend;
  logic              r_drop;        // snoop hit while still requesting
  logic              r_memreq;
  logic              r_busy;

  logic    w_rdv_last, w_sn_hit, w_flush_any, w_fill_ok, w_kill;
  wr_req_t w_sweep, w_snoop, w_fill, w_wr;

  // Next-state decode and fill-write qualification.
  always_comb begin
    w_nxt       = r_state;
    w_fill_ok   = 1'b0;
    w_kill      = 1'b0;
    w_rdv_last  = MemRDV && (r_wcnt == OFF_W'(LINE_WORDS-1));
    w_sn_hit    = SnWR && same_line(SnA, r_base);
    w_flush_any = Flush || r_flush_pend;
    case (r_state)
      ST_INIT:  if (r_cnt[IDX_W]) w_nxt = ST_IDLE;
      ST_IDLE: begin
        if (Flush)        w_nxt = ST_INIT;   // flush beats a same-cycle miss
        else if (MissReq) w_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (MemAck)
          w_nxt = (w_flush_any || r_drop || w_sn_hit) ? ST_DRAIN : ST_FILL;
      end
      ST_FILL: begin
        if (w_flush_any || w_sn_hit) begin
          w_kill = w_sn_hit;
          if (w_rdv_last) w_nxt = w_flush_any ? ST_INIT : ST_IDLE;
          else            w_nxt = ST_DRAIN;
        end else if (MemRDV) begin
          w_fill_ok = 1'b1;
          if (w_rdv_last) w_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: if (w_rdv_last) w_nxt = w_flush_any ? ST_INIT : ST_IDLE;
      default:  w_nxt = ST_INIT;
    endcase
  end

  // Write-port request sources.
  assign w_sweep = '{vld: (w_nxt == ST_INIT), a: ADDR_W'(r_cnt[IDX_W-1:0]),
                     d: '0, m: 4'hF, clr: 1'b1, last: 1'b0};
  assign w_snoop = '{vld: SnWR && (r_state != ST_INIT), a: SnA, d: SnD,
                     m: SnM, clr: 1'b0, last: 1'b0};
  assign w_fill  = '{vld: w_fill_ok, a: fill_addr(r_base, r_wcnt), d: MemRD,
                     m: 4'hF, clr: 1'b0, last: w_rdv_last};

  // Sequencer state, counters and memory-side request.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= ST_INIT;
      r_cnt        <= '0;
      r_wcnt       <= '0;
      r_base       <= '0;
      r_flush_pend <= 1'b0;
      r_drop       <= 1'b0;
      r_memreq     <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      r_state <= w_nxt;
      // sweep index advances on every cycle that emits a sweep write
      r_cnt   <= (w_nxt == ST_INIT) ? r_cnt + 1'b1 : '0;
      if (r_state == ST_REQ && MemAck)
        r_wcnt <= '0;
      else if ((r_state == ST_FILL || r_state == ST_DRAIN) && MemRDV)
        r_wcnt <= r_wcnt + 1'b1;
      if (r_state == ST_IDLE && MissReq && !Flush)
        r_base <= MissA;
      r_flush_pend <= (w_nxt != ST_INIT) &&
                      (r_flush_pend ||
                       (Flush && (r_state inside {ST_REQ, ST_FILL, ST_DRAIN})));
      r_drop   <= (r_state == ST_REQ) && (r_drop || w_sn_hit);
      r_memreq <= (w_nxt == ST_REQ);
      r_busy   <= (w_nxt != ST_IDLE);
    end
  end

  prefetch_wr_mux u_wr_mux (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_sweep (w_sweep),
    .i_snoop (w_snoop),
    .i_fill  (w_fill),
    .i_kill  (w_kill),
    .o_wr    (w_wr)
  );

  assign WR       = w_wr.vld;
  assign WRA      = w_wr.a;
  assign WRD      = w_wr.d;
  assign WRM      = w_wr.m;
  assign CLR      = w_wr.clr;
  assign FillDone = w_wr.last;
  assign MemReq   = r_memreq;
  assign MemA     = r_base;
  assign Busy     = r_busy;

endmodule
